// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and encodings for the hazard/forwarding controller and the EXE operand muxes.
package hazard_forward_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_MEM = 2'b01;
  localparam logic [1:0] FWD_SEL_WB  = 2'b10;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  use1;
    logic                  use2;
  } exe_tag_t;

  typedef struct packed {
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] dest;
  } wb_tag_t;

  function automatic logic tag_match(input logic                  valid,
                                     input logic                  wb_en,
                                     input logic [REG_ADDR_W-1:0] dest,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic                  use_bit);
    return valid & wb_en & use_bit & (dest == src);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_stage_tag.sv
// Per-stage shadow tag register: holds on i_hold, loads a bubble on i_bubble.
module hazard_stage_tag #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_hold,
  input  logic         i_bubble,
  input  logic         i_valid,
  input  logic [W-1:0] i_tag,
  output logic         o_valid,
  output logic [W-1:0] o_tag
);

  logic         r_valid;
  logic [W-1:0] r_tag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_valid <= 1'b0;
        r_tag   <= '0;
      end else begin
        r_valid <= i_valid;
        // Fields only move with a real instruction; valid alone marks an empty slot.
        if (i_valid) r_tag <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadow EXE/MEM/WB tags drive operand selects,
// RAW stall, branch flush, memory freeze and a saturating stall counter.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fwd_en,
  input  logic                  i_mem_freeze,
  input  logic                  i_branch_taken,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_uses_src1,
  input  logic                  i_id_uses_src2,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_id_wb_en,
  input  logic                  i_id_mem_read,
  output logic [1:0]            o_alu_mux_src_1_sel,
  output logic [1:0]            o_alu_mux_src_2_sel,
  output logic                  o_hazard_stall,
  output logic                  o_flush,
  output logic                  o_pipe_freeze,
  output logic [CNT_W-1:0]      o_stall_count
);

  exe_tag_t         w_id_tag;
  exe_tag_t         w_exe_tag;
  wb_tag_t          w_exe_out;
  wb_tag_t          w_mem_tag;
  wb_tag_t          w_wb_tag;
  logic             w_exe_valid;
  logic             w_mem_valid;
  logic             w_wb_valid;
  logic             w_raw;
  logic             w_exe_bubble;
  logic [CNT_W-1:0] r_stall_count;

  assign w_id_tag = '{
    wb_en:    i_id_wb_en,
    mem_read: i_id_mem_read,
    dest:     i_id_dest,
    src1:     i_id_src1,
    src2:     i_id_src2,
    use1:     i_id_uses_src1,
    use2:     i_id_uses_src2
  };

  assign w_exe_out    = '{wb_en: w_exe_tag.wb_en, dest: w_exe_tag.dest};
  assign w_exe_bubble = o_flush | o_hazard_stall;

  hazard_stage_tag #(.W($bits(exe_tag_t))) u_exe_tag (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hold   (i_mem_freeze),
    .i_bubble (w_exe_bubble),
    .i_valid  (i_id_valid),
    .i_tag    (w_id_tag),
    .o_valid  (w_exe_valid),
    .o_tag    (w_exe_tag)
  );

  hazard_stage_tag #(.W($bits(wb_tag_t))) u_mem_tag (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hold   (i_mem_freeze),
    .i_bubble (1'b0),
    .i_valid  (w_exe_valid),
    .i_tag    (w_exe_out),
    .o_valid  (w_mem_valid),
    .o_tag    (w_mem_tag)
  );

  hazard_stage_tag #(.W($bits(wb_tag_t))) u_wb_tag (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hold   (i_mem_freeze),
    .i_bubble (1'b0),
    .i_valid  (w_mem_valid),
    .i_tag    (w_mem_tag),
    .o_valid  (w_wb_valid),
    .o_tag    (w_wb_tag)
  );

  always_comb begin
    o_alu_mux_src_1_sel = FWD_SEL_RF;
    o_alu_mux_src_2_sel = FWD_SEL_RF;
    if (i_fwd_en && w_exe_valid) begin
      // MEM holds the younger result, so it wins over WB.
      if (tag_match(w_mem_valid, w_mem_tag.wb_en, w_mem_tag.dest, w_exe_tag.src1,
                    w_exe_tag.use1)) begin
        o_alu_mux_src_1_sel = FWD_SEL_MEM;
      end else if (tag_match(w_wb_valid, w_wb_tag.wb_en, w_wb_tag.dest, w_exe_tag.src1,
                             w_exe_tag.use1)) begin
        o_alu_mux_src_1_sel = FWD_SEL_WB;
      end
      if (tag_match(w_mem_valid, w_mem_tag.wb_en, w_mem_tag.dest, w_exe_tag.src2,
                    w_exe_tag.use2)) begin
        o_alu_mux_src_2_sel = FWD_SEL_MEM;
      end else if (tag_match(w_wb_valid, w_wb_tag.wb_en, w_wb_tag.dest, w_exe_tag.src2,
                             w_exe_tag.use2)) begin
        o_alu_mux_src_2_sel = FWD_SEL_WB;
      end
    end
  end

  always_comb begin
    logic exe_hit;
    logic mem_hit;
    exe_hit = tag_match(w_exe_valid, w_exe_tag.wb_en, w_exe_tag.dest, i_id_src1, i_id_uses_src1)
            | tag_match(w_exe_valid, w_exe_tag.wb_en, w_exe_tag.dest, i_id_src2, i_id_uses_src2);
    mem_hit = tag_match(w_mem_valid, w_mem_tag.wb_en, w_mem_tag.dest, i_id_src1, i_id_uses_src1)
            | tag_match(w_mem_valid, w_mem_tag.wb_en, w_mem_tag.dest, i_id_src2, i_id_uses_src2);
    w_raw = 1'b0;
    if (i_id_valid) begin
      if (i_fwd_en) w_raw = exe_hit & w_exe_tag.mem_read;
      else          w_raw = exe_hit | mem_hit;
    end
  end

  assign o_flush        = i_branch_taken & ~i_mem_freeze;
  assign o_hazard_stall = w_raw & ~i_branch_taken & ~i_mem_freeze;
  assign o_pipe_freeze  = i_mem_freeze;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (o_hazard_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_count;

endmodule
